// File: rtl/vga_output.sv
// VGA timing generator: free-running H/V counters pull RGB565 pixels from the
// output FIFO and drive the DAC with syncs, blank and coordinates aligned.
module vga_output #(
  parameter int X_RES         = 800,
  parameter int Y_RES         = 600,
  parameter int H_FRONT_PORCH = 40,
  parameter int H_SYNC        = 128,
  parameter int H_BACK_PORCH  = 88,
  parameter int V_FRONT_PORCH = 1,
  parameter int V_SYNC        = 4,
  parameter int V_BACK_PORCH  = 23,
  parameter bit SYNC_ACTIVE   = 1'b1
) (
  input  logic        hw_pixel_clk,
  input  logic        hw_rst_n,
  input  logic [15:0] fifo_read_data,
  input  logic        fifo_empty,
  output logic        fifo_read_request,
  input  logic        underflow_clear,
  output logic [15:0] hw_rgb_out,
  output logic        hw_hsync_out,
  output logic        hw_vsync_out,
  output logic        hw_blank_n,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        frame_start,
  output logic        underflow_flag,
  output logic [15:0] underflow_count
);

  localparam int H_TOTAL = X_RES + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = Y_RES + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int HS_BEG  = X_RES + H_FRONT_PORCH;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = Y_RES + V_FRONT_PORCH;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  typedef struct packed {
    logic        valid;
    logic        active;
    logic        hs;
    logic        vs;
    logic        starve;
    logic [10:0] h;
    logic [10:0] v;
  } st1_t;

  logic [10:0] h;
  logic [10:0] v;
  logic        active0;
  logic        hs0;
  logic        vs0;
  st1_t        s1;

  assign active0 = (h < 11'(X_RES)) && (v < 11'(Y_RES));
  assign hs0     = (h >= 11'(HS_BEG)) && (h < 11'(HS_END));
  assign vs0     = (v >= 11'(VS_BEG)) && (v < 11'(VS_END));

  assign fifo_read_request = active0 && !fifo_empty && hw_rst_n;

  always_ff @(posedge hw_pixel_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? 11'd0 : v + 11'd1;
    end else begin
      h <= h + 11'd1;
    end
  end

  // valid keeps the reset-time zeros in s1 from faking a frame_start
  always_ff @(posedge hw_pixel_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      s1 <= '0;
    end else begin
      s1 <= '{valid:  1'b1,
              active: active0,
              hs:     hs0,
              vs:     vs0,
              starve: active0 && fifo_empty,
              h:      h,
              v:      v};
    end
  end

  always_ff @(posedge hw_pixel_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      hw_rgb_out   <= '0;
      hw_blank_n   <= 1'b0;
      hw_hsync_out <= ~SYNC_ACTIVE;
      hw_vsync_out <= ~SYNC_ACTIVE;
      pixel_x      <= '0;
      pixel_y      <= '0;
      frame_start  <= 1'b0;
    end else begin
      hw_rgb_out   <= (s1.active && !s1.starve) ? fifo_read_data : 16'h0000;
      hw_blank_n   <= s1.active;
      hw_hsync_out <= s1.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      hw_vsync_out <= s1.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      pixel_x      <= s1.h;
      pixel_y      <= s1.v;
      frame_start  <= s1.valid && (s1.h == 11'd0) && (s1.v == 11'd0);
    end
  end

  // a clear in the same cycle as a starved pixel keeps that pixel counted
  always_ff @(posedge hw_pixel_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      underflow_flag  <= 1'b0;
      underflow_count <= '0;
    end else if (underflow_clear) begin
      underflow_flag  <= s1.starve;
      underflow_count <= {15'd0, s1.starve};
    end else if (s1.starve) begin
      underflow_flag <= 1'b1;
      if (underflow_count != 16'hFFFF)
        underflow_count <= underflow_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_output.sv
// Scoreboard bench for vga_output: a frame-position reference model queues
// expected DAC outputs; a negedge monitor pops and compares them.
module tb_vga_output;

  localparam int XR    = 20;
  localparam int YR    = 6;
  localparam int HFP   = 3;
  localparam int HSW   = 5;
  localparam int HBP   = 4;
  localparam int VFP   = 1;
  localparam int VSW   = 2;
  localparam int VBP   = 2;
  localparam int HT    = XR + HFP + HSW + HBP;
  localparam int VT    = YR + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read_request;
  logic        underflow_clear;
  logic [15:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        frame_start;
  logic        uf_flag;
  logic [15:0] uf_count;

  always #5 clk = ~clk;

  vga_output #(
    .X_RES(XR), .Y_RES(YR),
    .H_FRONT_PORCH(HFP), .H_SYNC(HSW), .H_BACK_PORCH(HBP),
    .V_FRONT_PORCH(VFP), .V_SYNC(VSW), .V_BACK_PORCH(VBP),
    .SYNC_ACTIVE(1'b1)
  ) dut (
    .hw_pixel_clk(clk),
    .hw_rst_n(rst_n),
    .fifo_read_data(fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_read_request(fifo_read_request),
    .underflow_clear(underflow_clear),
    .hw_rgb_out(rgb),
    .hw_hsync_out(hsync),
    .hw_vsync_out(vsync),
    .hw_blank_n(blank_n),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .frame_start(frame_start),
    .underflow_flag(uf_flag),
    .underflow_count(uf_count)
  );

  // FIFO device: hands out 0,1,2,... one cycle after each pop
  logic [15:0] fifo_word;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_word <= '0;
      fifo_data <= 16'hDEAD;
    end else if (fifo_read_request) begin
      fifo_data <= fifo_word;
      fifo_word <= fifo_word + 16'd1;
    end
  end

  typedef struct {
    logic        req;
    logic [15:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic        flag;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          t;
  int          mode;
  logic [15:0] m_word;
  logic [15:0] m_cnt;
  logic        m_flag;
  bit          clr_pend;

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      int   pos, h, v;
      bit   act, hs, vs, emp, clr_next, starve;
      exp_t e;
      pos = t % FRAME;
      h = pos % HT;
      v = pos / HT;
      act = (h < XR) && (v < YR);
      hs = (h >= XR + HFP) && (h < XR + HFP + HSW);
      vs = (v >= YR + VFP) && (v < YR + VFP + VSW);
      emp = 1'b0;
      clr_next = 1'b0;
      case (mode)
        1: begin
          emp = (v == 1 && h >= 8 && h <= 10) ||
                (v == 1 && h >= XR + 1 && h <= XR + 3) ||
                (v == 4 && h == 5);
          clr_next = (v == 3 && h == 0) || (v == 4 && h == 5);
        end
        2: begin
          emp = ($urandom_range(5) == 0);
          clr_next = ($urandom_range(9) == 0);
        end
        default: ;
      endcase
      fifo_empty = emp;
      underflow_clear = clr_pend;
      clr_pend = clr_next;
      starve = act && emp;
      e.req = act && !emp;
      e.rgb = e.req ? m_word : 16'h0000;
      if (e.req) m_word++;
      if (clr_next) begin
        m_flag = starve;
        m_cnt = starve ? 16'd1 : 16'd0;
      end else if (starve) begin
        m_flag = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      e.hs = hs;
      e.vs = vs;
      e.blank = act;
      e.fs = (h == 0) && (v == 0);
      e.flag = m_flag;
      e.x = 11'(h);
      e.y = 11'(v);
      e.cnt = m_cnt;
      q.push_back(e);
      t++;
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && q.size() > 0) begin
      checks++;
      if (fifo_read_request !== q[$].req) begin
        errors++;
        $display("FAIL req @%0t: got %0b exp %0b", $time,
                 fifo_read_request, q[$].req);
      end
      checks++;
      if (q.size() >= 3) begin
        me = q.pop_front();
        if ({rgb, hsync, vsync, blank_n, frame_start, uf_flag,
             pixel_x, pixel_y, uf_count} !==
            {me.rgb, me.hs, me.vs, me.blank, me.fs, me.flag,
             me.x, me.y, me.cnt}) begin
          errors++;
          $display("FAIL out @%0t: got rgb=%h hs=%b vs=%b bl=%b fs=%b fl=%b x=%0d y=%0d c=%0d exp rgb=%h hs=%b vs=%b bl=%b fs=%b fl=%b x=%0d y=%0d c=%0d",
                   $time, rgb, hsync, vsync, blank_n, frame_start, uf_flag,
                   pixel_x, pixel_y, uf_count, me.rgb, me.hs, me.vs,
                   me.blank, me.fs, me.flag, me.x, me.y, me.cnt);
        end
      end else if (frame_start !== 1'b0 || blank_n !== 1'b0) begin
        errors++;
        $display("FAIL startup @%0t: got fs=%b bl=%b exp fs=0 bl=0",
                 $time, frame_start, blank_n);
      end
    end
  end

  task automatic chk_reset(input string tag);
    checks++;
    if ({rgb, hsync, vsync, blank_n, frame_start, uf_flag, pixel_x,
         pixel_y, uf_count, fifo_read_request} !== '0) begin
      errors++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b bl=%b fs=%b fl=%b x=%0d y=%0d c=%0d req=%b exp all zero",
               tag, rgb, hsync, vsync, blank_n, frame_start, uf_flag,
               pixel_x, pixel_y, uf_count, fifo_read_request);
    end
  endtask

  task automatic model_reset();
    q.delete();
    t = 0;
    m_word = '0;
    m_cnt = '0;
    m_flag = 1'b0;
    clr_pend = 1'b0;
    underflow_clear = 1'b0;
  endtask

  initial begin
    fifo_empty = 1'b0;
    mode = 0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_hold");
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_cycles(2 * FRAME);
    mode = 1;
    run_cycles(FRAME);
    mode = 2;
    run_cycles(FRAME);
    mode = 0;
    run_cycles(3 * HT + 10);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    repeat (3) @(posedge clk);
    #1;
    chk_reset("mid_reset_hold");
    model_reset();
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_cycles(FRAME + 4);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
